regfile_dump: RTL

- Reader-side companion to the 3-port register file (2 async read ports, 1 sync write port).
- On a start pulse, walks every register pairwise through read ports 1 and 2 and streams (address, value) beats out over a valid/ready interface.
- Used for architectural-state dumps to the bench, debug, and checkpointing.
- Runs concurrently with normal writes; each beat carries the register value as of its capture edge.

---
 rtl/regfile_dump.sv | 100 ++++++++++
 1 files changed

// File: rtl/regfile_dump.sv
// Register-file dump engine: walks every register pair through the two async
// read ports and streams (address, value) beats out over a valid/ready interface.
module regfile_dump #(
   parameter int NREGS = 32,
   parameter int AW    = 5,
   parameter int DW    = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   output logic          busy,
   output logic          done,
   output logic [AW-1:0] ra1,
   output logic [AW-1:0] ra2,
   input  logic [DW-1:0] rd1,
   input  logic [DW-1:0] rd2,
   input  logic          we3,
   input  logic [AW-1:0] wa3,
   input  logic [DW-1:0] wd3,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [AW-1:0] out_addr,
   output logic [DW-1:0] out_data
);

   typedef enum logic [2:0] {IDLE, READ, SEND0, SEND1, DONE} state_t;

   localparam logic [AW-1:0] LAST_PTR = AW'(NREGS - 2);

   state_t        state, state_nxt;
   logic [AW-1:0] ptr;
   logic [AW-1:0] ptr_odd;
   logic [DW-1:0] buf0, buf1;
   logic          fwd0, fwd1;

   // ptr is always even, so the odd partner is formed by setting bit 0; this
   // keeps ra2 in range without an adder.
   assign ptr_odd = {ptr[AW-1:1], 1'b1};
   assign ra1     = ptr;
   assign ra2     = ptr_odd;

   // A write landing on the capture edge must win over the stale read data.
   assign fwd0 = we3 && (wa3 == ptr)     && (wa3 != '0);
   assign fwd1 = we3 && (wa3 == ptr_odd) && (wa3 != '0);

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      // NOTE: default first so no path leaves state_nxt unassigned (no latch).
      state_nxt = state;
      unique case (state)
         IDLE:    if (start) state_nxt = READ;
         READ:    state_nxt = SEND0;
         SEND0:   if (out_ready) state_nxt = SEND1;
         SEND1:   if (out_ready) state_nxt = (ptr == LAST_PTR) ? DONE : READ;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr  <= '0;
         buf0 <= '0;
         buf1 <= '0;
      end else begin
         unique case (state)
            IDLE: if (start) ptr <= '0;
            READ: begin
               buf0 <= fwd0 ? wd3 : rd1;
               buf1 <= fwd1 ? wd3 : rd2;
            end
            SEND1: if (out_ready && ptr != LAST_PTR) ptr <= ptr + AW'(2);
            DONE:  ptr <= '0;
            default: ;
         endcase
      end
   end

   always_comb begin
      busy      = (state != IDLE);
      done      = (state == DONE);
      out_valid = (state == SEND0) || (state == SEND1);
      out_addr  = '0;
      out_data  = '0;
      if (state == SEND0) begin
         out_addr = ptr;
         out_data = buf0;
      end else if (state == SEND1) begin
         out_addr = ptr_odd;
         out_data = buf1;
      end
   end

endmodule
